// File: rtl/mem_req_pkg.sv
// mem_req_pkg: scheduler FSM state encoding and row/column address split helper
package mem_req_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WR_HOLD, RD_WAIT, RD_CAP, RESP} sched_state_t;
  localparam int ROW_W = 4;
  localparam int COL_W = 12;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } addr_split_t;
  function automatic addr_split_t split_addr(input logic [ROW_W+COL_W-1:0] addr);
    return '{row: addr[15:12], col: addr[11:0]};
  endfunction
endpackage

// File: rtl/req_fifo.sv
// req_fifo: request FIFO (push/pop, din/dout head, full/empty, count 0..DEPTH)
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_req_sched.sv
// mem_req_sched: host req valid/ready -> FIFO -> one-at-a-time mc_* command issue -> rsp_* completion pulse
module mem_req_sched #(
  parameter int DEPTH = 4,
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int WR_HOLD = 6,
  parameter int RD_TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rnw,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_rnw,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          mc_cmd_n,
  output logic          mc_rdnwr,
  output logic [AW-1:0] mc_addr,
  output logic          mc_wvld,
  output logic [DW-1:0] mc_wdata,
  input  logic [DW-1:0] mc_rdata,
  input  logic          mc_rvld
);
  import mem_req_pkg::*;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int EW = 1 + AW + DW;
  localparam int TW = $clog2((WR_HOLD > RD_TIMEOUT ? WR_HOLD : RD_TIMEOUT) + 1);
  sched_state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic push, pop, full, empty, timeout;
  logic [CNTW-1:0] fifo_count;
  logic [EW-1:0] head;
  logic cur_rnw;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  assign req_ready = fifo_count < CNTW'(DEPTH);
  assign push = req_valid && !full;
  req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({req_rnw, req_addr, req_wdata}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pop = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : ISSUE;
      end
      ISSUE: begin
        state_n = cur_rnw ? RD_WAIT : mem_req_pkg::WR_HOLD;
        cnt_n = cur_rnw ? '0 : TW'(WR_HOLD - 1);
      end
      mem_req_pkg::WR_HOLD: begin
        state_n = cnt == '0 ? RESP : mem_req_pkg::WR_HOLD;
        cnt_n = cnt == '0 ? '0 : cnt - TW'(1);
      end
      RD_WAIT: begin
        timeout = !mc_rvld && cnt == TW'(RD_TIMEOUT - 1);
        state_n = mc_rvld ? RD_CAP : timeout ? RESP : RD_WAIT;
        cnt_n = mc_rvld || timeout ? cnt : cnt + TW'(1);
      end
      RD_CAP: state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_rnw <= 1'b0;
      cur_addr <= '0;
      cur_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rnw <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      mc_cmd_n <= 1'b1;
      mc_rdnwr <= 1'b0;
      mc_addr <= '0;
      mc_wvld <= 1'b0;
      mc_wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (pop) begin
        {cur_rnw, cur_addr, cur_wdata} <= head;
        mc_rdnwr <= head[EW-1];
        mc_addr <= head[DW +: AW];
      end
      mc_cmd_n <= state_n != ISSUE;
      mc_wvld <= state_n == mem_req_pkg::WR_HOLD;
      if (state_n == mem_req_pkg::WR_HOLD) mc_wdata <= cur_wdata;
      rsp_valid <= state_n == RESP;
      if (state_n == RESP) begin
        rsp_rnw <= cur_rnw;
        rsp_err <= timeout;
        rsp_rdata <= state == RD_CAP ? mc_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_req_sched.sv
// tb_mem_req_sched: directed scoreboard bench for mem_req_sched with a simple controller read model
module tb_mem_req_sched;
  localparam int AW = 16;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid, req_ready, req_rnw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic rsp_valid, rsp_rnw, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic mc_cmd_n, mc_rdnwr, mc_wvld, mc_rvld;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_wdata, mc_rdata;
  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  logic [33:0] sb[$];
  bit rd_en = 1'b1;
  int rd_cd = 0;
  bit rd_cap_pending = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  always #5 clk = ~clk;
  mem_req_sched #(.DEPTH(4), .AW(AW), .DW(DW), .WR_HOLD(6), .RD_TIMEOUT(63)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rnw(rsp_rnw), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mc_cmd_n(mc_cmd_n), .mc_rdnwr(mc_rdnwr), .mc_addr(mc_addr),
    .mc_wvld(mc_wvld), .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_rvld(mc_rvld)
  );
  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return (a == 16'h2010) ? 32'hCAFEF00D : {16'hA5A5, a};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    mc_rvld = 1'b0;
    mc_rdata = 32'hBAD0BAD0;
    if (rd_cap_pending) begin
      mc_rdata = mdata(rd_addr);
      rd_cap_pending = 1'b0;
    end
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin
        mc_rvld = 1'b1;
        rd_cap_pending = 1'b1;
      end
    end
    if (!mc_cmd_n && mc_rdnwr && rd_en) begin
      rd_cd = 5;
      rd_addr = mc_addr;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rsp_unexpected observed=1 expected=0");
      end else chk("rsp", 64'({rsp_rnw, rsp_err, rsp_rdata}), 64'(sb.pop_front()));
    end
  endtask
  task automatic send(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_rnw = rnw;
    req_addr = a;
    req_wdata = d;
    while (!req_ready && n < 300) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end else sb.push_back({rnw, rnw && !rd_en, (rnw && rd_en) ? mdata(a) : 32'h0});
    tick();
    req_valid = 1'b0;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rsp_valid && n < 400);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
  endtask
  initial begin
    int n, wv, base;
    req_valid = 1'b0;
    req_rnw = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    mc_rvld = 1'b0;
    mc_rdata = '0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rnw", rsp_rnw, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mc_cmd_n", mc_cmd_n, 1);
    chk("rst_mc_rdnwr", mc_rdnwr, 0);
    chk("rst_mc_addr", mc_addr, 0);
    chk("rst_mc_wvld", mc_wvld, 0);
    chk("rst_mc_wdata", mc_wdata, 0);
    rst = 1'b0;
    tick();
    send(0, 16'h0100, 32'h1);
    send(0, 16'h0200, 32'h2);
    send(0, 16'h0300, 32'h3);
    send(0, 16'h0400, 32'h4);
    chk("mid_wvld", mc_wvld, 1);
    chk("mid_count", 64'(dut.fifo_count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    rd_cd = 0;
    rd_cap_pending = 1'b0;
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_mc_cmd_n", mc_cmd_n, 1);
    chk("mrst_mc_wvld", mc_wvld, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_count", 64'(dut.fifo_count), 0);
    n = 0;
    repeat (20) begin
      tick();
      if (!mc_cmd_n || mc_wvld) n++;
    end
    chk("mrst_no_activity", n, 0);
    send(0, 16'h1234, 32'hDEADBEEF);
    chk("wr_c1_cmd_n", mc_cmd_n, 1);
    tick();
    chk("wr_c2_cmd_n", mc_cmd_n, 0);
    chk("wr_c2_rdnwr", mc_rdnwr, 0);
    chk("wr_c2_addr", mc_addr, 16'h1234);
    chk("wr_c2_wvld", mc_wvld, 0);
    wv = 0;
    repeat (6) begin
      tick();
      if (mc_wvld && mc_wdata == 32'hDEADBEEF && mc_cmd_n && !rsp_valid) wv++;
    end
    chk("wr_hold_cycles", wv, 6);
    tick();
    chk("wr_c9_rsp_valid", rsp_valid, 1);
    chk("wr_c9_wvld", mc_wvld, 0);
    chk("wr_c9_addr_hold", mc_addr, 16'h1234);
    chk("wr_c9_wdata_hold", mc_wdata, 32'hDEADBEEF);
    tick();
    rd_en = 1'b1;
    send(1, 16'h2010, 32'h0);
    tick();
    chk("rd_cmd_n", mc_cmd_n, 0);
    chk("rd_rdnwr", mc_rdnwr, 1);
    chk("rd_addr", mc_addr, 16'h2010);
    wait_rsp(n);
    chk("rd_latency", n, 7);
    tick();
    rd_en = 1'b0;
    send(1, 16'h3000, 32'h0);
    send(0, 16'h4000, 32'h11112222);
    chk("to_cmd_n", mc_cmd_n, 0);
    wait_rsp(n);
    chk("to_latency", n, 64);
    chk("to_err", rsp_err, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (mc_cmd_n && n < 20);
    chk("to_next_issue", n, 2);
    chk("to_next_addr", mc_addr, 16'h4000);
    wait_rsp(n);
    chk("to_next_latency", n, 7);
    rd_en = 1'b1;
    tick();
    base = rsp_cnt;
    send(0, 16'h5000, 32'h5);
    send(1, 16'h5100, 32'h0);
    send(0, 16'h5200, 32'h7);
    send(1, 16'h5300, 32'h0);
    send(0, 16'h5400, 32'h9);
    chk("bp_ready", req_ready, 0);
    chk("bp_count", 64'(dut.fifo_count), 4);
    send(1, 16'h5500, 32'h0);
    drain();
    chk("bp_rsp_count", rsp_cnt - base, 6);
    repeat (3) tick();
    send(1, 16'h6000, 32'h0);
    send(1, 16'h6100, 32'h0);
    send(1, 16'h6200, 32'h0);
    chk("wrap_count_c3", 64'(dut.fifo_count), 2);
    wait_rsp(n);
    chk("wrap_a_latency", n, 6);
    tick();
    chk("wrap_count_c10", 64'(dut.fifo_count), 2);
    send(1, 16'h6300, 32'h0);
    chk("wrap_count_c11", 64'(dut.fifo_count), 2);
    drain();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
